// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and helpers for serial_wide_adder
//
// Purpose : FSM state encoding and slice-count helper used by the serial adder.
// Ports   : none (package).
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } swa_state_t;

  // Number of CHUNK-wide slices that make up one operand.
  function automatic int calc_nchunk(input int operand_width, input int chunk_width);
    return operand_width / chunk_width;
  endfunction

endpackage

// File: rtl/carry_skip_adder.sv
// rtl/carry_skip_adder.sv - combinational carry-skip adder, one chunk wide
//
// Purpose : sum_o/carry_o = a_i + b_i + carry_i over DATA_WIDTH bits, organised
//           as ripple blocks of BLOCK_WIDTH bits with a block-level skip path.
// Ports   : a_i, b_i   [DATA_WIDTH] addends
//           carry_i    carry into bit 0
//           sum_o      [DATA_WIDTH] sum
//           carry_o    carry out of the MSB
module carry_skip_adder #(
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  carry_i,
  output logic [DATA_WIDTH-1:0] sum_o,
  output logic                  carry_o
);

  localparam int NBLK = DATA_WIDTH / BLOCK_WIDTH;

  if (DATA_WIDTH % BLOCK_WIDTH != 0) begin : g_bad_block
    $error("carry_skip_adder: DATA_WIDTH must be a multiple of BLOCK_WIDTH");
  end

  logic c;      // carry entering the current block
  logic bc;     // ripple carry inside the current block
  logic p;      // bit propagate
  logic prop;   // whole-block propagate: block passes its carry-in straight through

  // Single process so the block-to-block carry chain is one ordered walk.
  always_comb begin
    sum_o = '0;
    c     = carry_i;
    bc    = 1'b0;
    p     = 1'b0;
    prop  = 1'b0;
    for (int blk = 0; blk < NBLK; blk++) begin
      bc   = c;
      prop = 1'b1;
      for (int i = 0; i < BLOCK_WIDTH; i++) begin
        p = a_i[blk*BLOCK_WIDTH+i] ^ b_i[blk*BLOCK_WIDTH+i];
        sum_o[blk*BLOCK_WIDTH+i] = p ^ bc;
        bc   = (a_i[blk*BLOCK_WIDTH+i] & b_i[blk*BLOCK_WIDTH+i]) | (p & bc);
        prop = prop & p;
      end
      // Skip: a fully propagating block forwards its input carry directly.
      c = prop ? c : bc;
    end
    carry_o = c;
  end

endmodule

// File: rtl/serial_wide_adder.sv
// rtl/serial_wide_adder.sv - multi-cycle wide adder/subtractor, one slice per cycle
//
// Purpose : computes A + B' + carry_i (B' = ~B when sub_i) over OPERAND_WIDTH bits,
//           CHUNK_WIDTH bits per cycle LSB-first through one carry_skip_adder.
// Ports   : clk_i, rst_i (sync, active-high)
//           valid_i/ready_o            request handshake
//           operand_A_i, operand_B_i   operands; carry_i initial carry; sub_i invert B
//           valid_o/ready_i            result handshake
//           result_o, carry_o, overflow_o   result, MSB carry-out, signed overflow
module serial_wide_adder
  import adder_pkg::*;
#(
  parameter int OPERAND_WIDTH = 128,
  parameter int CHUNK_WIDTH   = 32,
  parameter int BLOCK_WIDTH   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [OPERAND_WIDTH-1:0] operand_A_i,
  input  logic [OPERAND_WIDTH-1:0] operand_B_i,
  input  logic                     carry_i,
  input  logic                     sub_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [OPERAND_WIDTH-1:0] result_o,
  output logic                     carry_o,
  output logic                     overflow_o
);

  localparam int NCHUNK = calc_nchunk(OPERAND_WIDTH, CHUNK_WIDTH);
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if (OPERAND_WIDTH % CHUNK_WIDTH != 0) begin : g_bad_chunk
    $error("serial_wide_adder: OPERAND_WIDTH must be a multiple of CHUNK_WIDTH");
  end
  if (CHUNK_WIDTH % BLOCK_WIDTH != 0) begin : g_bad_block
    $error("serial_wide_adder: CHUNK_WIDTH must be a multiple of BLOCK_WIDTH");
  end

  swa_state_t state_q, state_d;

  logic [NCHUNK-1:0][CHUNK_WIDTH-1:0] a_q, b_q, result_q;
  logic [IDX_W-1:0]                   idx_q;
  logic                               carry_q;
  logic                               carry_out_q;
  logic                               overflow_q;

  logic [CHUNK_WIDTH-1:0] a_slice, b_slice, sum;
  logic                   slice_cout;
  logic                   accept;
  logic                   last_slice;

  assign a_slice    = a_q[idx_q];
  assign b_slice    = b_q[idx_q];
  assign accept     = (state_q == IDLE) && valid_i;
  assign last_slice = (state_q == BUSY) && (idx_q == LAST_IDX);

  carry_skip_adder #(
    .DATA_WIDTH (CHUNK_WIDTH),
    .BLOCK_WIDTH(BLOCK_WIDTH)
  ) u_adder (
    .a_i    (a_slice),
    .b_i    (b_slice),
    .carry_i(carry_q),
    .sum_o  (sum),
    .carry_o(slice_cout)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_d = BUSY;
      end
      BUSY: begin
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (accept) begin
      a_q      <= operand_A_i;
      b_q      <= sub_i ? ~operand_B_i : operand_B_i;
      carry_q  <= carry_i;
      idx_q    <= '0;
      result_q <= '0;
    end else if (state_q == BUSY) begin
      result_q[idx_q] <= sum;
      carry_q         <= slice_cout;
      if (idx_q != LAST_IDX) idx_q <= idx_q + IDX_W'(1);
      if (last_slice) begin
        carry_out_q <= slice_cout;
        // Carry into the MSB recovered from its sum bit, compared with carry out.
        overflow_q  <= (a_slice[CHUNK_WIDTH-1] ^ b_slice[CHUNK_WIDTH-1] ^ sum[CHUNK_WIDTH-1])
                       ^ slice_cout;
      end
    end
  end

  assign result_o   = result_q;
  assign carry_o    = carry_out_q;
  assign overflow_o = overflow_q;

endmodule

// File: doc/serial_wide_adder.md
Name: serial_wide_adder

Overview:
- Multi-cycle adder/subtractor for operands wider than a single adder instance can handle.
- Processes OPERAND_WIDTH-bit operands one CHUNK_WIDTH slice per cycle, LSB slice first, through one internal carry_skip_adder instance.
- Carries between slices in a register.
- Sits upstream of wide-arithmetic consumers (multi-precision multiply/accumulate). Trades latency for area.

Parameters:
- OPERAND_WIDTH, 128, total operand/result width.
- CHUNK_WIDTH, 32, bits added per cycle (the internal adder's DATA_WIDTH).
- BLOCK_WIDTH, 4, skip-block width passed to the internal adder.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- valid_i  input  1  request valid.
- ready_o  output  1  block can accept a request.
- operand_A_i  input  OPERAND_WIDTH  addend A.
- operand_B_i  input  OPERAND_WIDTH  addend B.
- carry_i  input  1  initial carry-in.
- sub_i  input  1  1: use ~operand_B_i in place of B.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts result.
- result_o  output  OPERAND_WIDTH  A + B' + carry_i, modulo 2^OPERAND_WIDTH.
- carry_o  output  1  carry out of the MSB.
- overflow_o  output  1  two's-complement signed overflow.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- Parameter legality: NCHUNK = OPERAND_WIDTH / CHUNK_WIDTH. OPERAND_WIDTH must be a multiple of CHUNK_WIDTH, and CHUNK_WIDTH a multiple of BLOCK_WIDTH. Either violation is an elaboration-time error.
- FSM states and transitions:
  - IDLE: ready_o=1, valid_o=0. On an edge with valid_i=1, go to BUSY.
  - BUSY: ready_o=0, valid_o=0. Go to DONE on the edge where idx==NCHUNK-1.
  - DONE: ready_o=0, valid_o=1. On an edge with ready_i=1, go to IDLE.
- Accept edge (IDLE, valid_i=1):
  - Register A and B' = sub_i ? ~operand_B_i : operand_B_i.
  - carry_reg <= carry_i; idx <= 0; result register <= 0.
- Each BUSY cycle:
  - Internal adder computes slice idx of A + slice idx of B' + carry_reg, combinationally.
  - At the edge: result slice idx <= sum; carry_reg <= adder carry-out; idx <= idx+1.
- Latency: valid_o rises exactly NCHUNK cycles after the accept edge. For the default, that is 4 cycles.
- Minimum request-to-request spacing is NCHUNK+2 cycles.
- overflow_o: computed on the final slice as (carry into MSB) XOR (carry out of MSB). Carry into MSB = A[MSB] ^ B'[MSB] ^ sum[MSB]. Registered with the final slice.
- DONE hold: result_o, carry_o and overflow_o are held stable while valid_o=1 and ready_i=0, with no cycle limit.
- Between operations: after leaving DONE, result_o, carry_o and overflow_o keep their last values.
- valid_i is ignored outside IDLE. Operands may change freely after the accept edge.
- In DONE, if valid_i=1 and ready_i=1 in the same cycle, the new request is not accepted. It is accepted in the following IDLE cycle.
- Reset (any state, including mid-BUSY):
  - Next state IDLE; ready_o=1, valid_o=0.
  - result_o=0, carry_o=0, overflow_o=0, idx=0, carry_reg=0.
  - Any partial result is discarded.
- Reset has priority over the handshake.
- idx width is $clog2(NCHUNK), minimum 1. idx never wraps past NCHUNK-1 in BUSY.

Decomposition:
- Shared package adder_pkg:
  - State enum swa_state_t {IDLE, BUSY, DONE}.
  - NCHUNK computation helper function.
- One sub-module: carry_skip_adder. Parameters DATA_WIDTH=CHUNK_WIDTH and BLOCK_WIDTH. It receives the slice muxed by idx and carry_reg.
- Control FSM, idx counter and result register stay in this module.

Test Plan (defaults):
- Carry propagation: A=all ones (128 bits), B=1, carry_i=0, sub_i=0 -> valid_o rises 4 cycles after accept; result_o=0, carry_o=1, overflow_o=0.
- Subtraction: A=5, B=7, sub_i=1, carry_i=1 -> result_o=0xFFFF...FFFE (-2), carry_o=0, overflow_o=0.
- Signed overflow: A=0x7FFF...FFFF, B=1 -> result_o=0x8000...0000, overflow_o=1, carry_o=0.
- Backpressure: ready_i=0 for 10 cycles in DONE, with valid_i toggling and new operands applied -> outputs constant, ready_o=0, no new accept. Raise ready_i -> IDLE next cycle.
- Mid-operation reset: rst_i pulsed on the 2nd BUSY cycle -> next cycle ready_o=1, valid_o=0, result_o=0. Then A=3, B=4 completes with result_o=7 after 4 cycles.
- Back-to-back: valid_i and ready_i tied 1, two requests (1+1, 2+2) -> accepts 6 cycles apart; results 2 then 4 in order; valid_o high one cycle each.
